// File: rtl/adc_pkg.sv
// Shared ADC constants: default decimation ratio, bitstream polarity and
// the word-width rule shared by the decimator and the output formatter.
package adc_pkg;

    localparam int   DECIMATION_DEF = 64;
    localparam logic BIT_POS        = 1'b1;

    // Second-order CIC growth: 2*log2(R) bits plus one to hold exactly R^2.
    function automatic int out_width(input int dec);
        return 2 * $clog2(dec) + 1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Rising-edge detector turning the divided sample clock into a one-cycle tick.
// Combinational output from one register; no backpressure.
module sample_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic sample_clk_i,
    output logic tick_o
);

    logic s_clk_d_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_clk_d_q <= 1'b0;
        end else begin
            s_clk_d_q <= sample_clk_i;
        end
    end

    assign tick_o = sample_clk_i & ~s_clk_d_q;

endmodule

// File: rtl/sinc2_decimator.sv
// Sinc2 decimator: outValid rises 2 clk edges after the frame-completing tick.
// A result arriving while the previous word is unaccepted overwrites it and sets sticky overrun.
module sinc2_decimator
    import adc_pkg::*;
#(
    parameter int DECIMATION = DECIMATION_DEF,
    parameter int DEC_W      = $clog2(DECIMATION),
    parameter int OUT_W      = out_width(DECIMATION)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sampleClk,
    input  logic             bitIn,
    input  logic             outReady,
    output logic [OUT_W-1:0] outData,
    output logic             outValid,
    output logic             overrun
);

    logic             tick;
    logic [OUT_W-1:0] inc;
    logic [OUT_W-1:0] c1;
    logic [OUT_W-1:0] c2;
    logic             load;

    logic [OUT_W-1:0] integ1_q, integ1_d;
    logic [OUT_W-1:0] integ2_q, integ2_d;
    logic [OUT_W-1:0] dly1_q, dly1_d;
    logic [OUT_W-1:0] dly2_q, dly2_d;
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
    logic             dump_pend_q, dump_pend_d;
    logic             primed_q, primed_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    sample_tick_gen u_tick (
        .clk          (clk),
        .rst          (rst),
        .sample_clk_i (sampleClk),
        .tick_o       (tick)
    );

    assign inc  = {{(OUT_W-1){1'b0}}, (bitIn == BIT_POS)};
    assign c1   = integ2_q - dly1_q;
    assign c2   = c1 - dly2_q;
    assign load = dump_pend_q & primed_q;

    always_comb begin
        integ1_d    = integ1_q;
        integ2_d    = integ2_q;
        dec_cnt_d   = dec_cnt_q;
        dump_pend_d = 1'b0;
        dly1_d      = dly1_q;
        dly2_d      = dly2_q;
        primed_d    = primed_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (tick) begin
            integ1_d    = integ1_q + inc;
            integ2_d    = integ2_q + integ1_q + inc;
            dec_cnt_d   = dec_cnt_q + 1'b1;
            dump_pend_d = (dec_cnt_q == DEC_W'(DECIMATION - 1));
        end

        // The first dump after reset only seeds the comb delays.
        if (dump_pend_q) begin
            dly1_d   = integ2_q;
            dly2_d   = c1;
            primed_d = 1'b1;
        end

        if (load) begin
            out_data_d  = c2;
            out_valid_d = 1'b1;
            overrun_d   = overrun_q | (out_valid_q & ~outReady);
        end else if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            integ1_q    <= '0;
            integ2_q    <= '0;
            dly1_q      <= '0;
            dly2_q      <= '0;
            dec_cnt_q   <= '0;
            dump_pend_q <= 1'b0;
            primed_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            integ1_q    <= integ1_d;
            integ2_q    <= integ2_d;
            dly1_q      <= dly1_d;
            dly2_q      <= dly2_d;
            dec_cnt_q   <= dec_cnt_d;
            dump_pend_q <= dump_pend_d;
            primed_q    <= primed_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign outData  = out_data_q;
    assign outValid = out_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sinc2_decimator.sv
// Bench for sinc2_decimator: triangular-kernel reference over the tick history,
// directed pattern steps plus randomized bits, sample-clock rate and outReady.
module tb_sinc2_decimator;

    localparam int N = 64;

    logic        clk;
    logic        rst;
    logic        sampleClk;
    logic        bitIn;
    logic        outReady;
    logic [12:0] outData;
    logic        outValid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    bit   hist[$];
    bit   m_valid;
    int   m_data;
    bit   m_ovr;
    bit   load_cd;
    int   pend_val;
    bit   prev_sclk;
    bit   ready_rand;
    int   valid_seen;

    sinc2_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .sampleClk (sampleClk),
        .bitIn     (bitIn),
        .outReady  (outReady),
        .outData   (outData),
        .outValid  (outValid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // A sinc2 output is the last 2N samples weighted by a triangle peaking at N.
    function automatic int frame_val();
        int s = 0;
        int n = hist.size();
        for (int d = 0; d < 2 * N; d++) begin
            int w = (d < N) ? d + 1 : 2 * N - 1 - d;
            s += w * int'(hist[n - 1 - d]);
        end
        return s;
    endfunction

    task automatic step();
        bit ld;
        bit xfer;
        int n;
        if (ready_rand) outReady = 1'($urandom_range(0, 1));
        if (!rst) begin
            hist.delete();
            m_valid   = 1'b0;
            m_data    = 0;
            m_ovr     = 1'b0;
            load_cd   = 1'b0;
            prev_sclk = 1'b0;
        end else begin
            ld      = load_cd;
            load_cd = 1'b0;
            xfer    = m_valid && outReady;
            if (ld) begin
                if (m_valid && !outReady) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_data  = pend_val;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
            if (sampleClk && !prev_sclk) begin
                hist.push_back(bitIn);
                n = hist.size();
                if (n % N == 0 && n >= 2 * N) begin
                    pend_val = frame_val();
                    load_cd  = 1'b1;
                end
            end
            prev_sclk = sampleClk;
        end
        @(posedge clk);
        #1;
        if (outValid === 1'b1) valid_seen++;
        chk("outValid", 32'(outValid), 32'(m_valid));
        chk("outData", 32'(outData), 32'(m_data));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    function automatic bit gen_bit(input int kind, input int i);
        case (kind)
            0: return 1'b0;
            1: return 1'b1;
            2: return (i % 2 == 0);
            3: return (i % 4 != 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Each sample: sampleClk high for 'half' cycles then low; bitIn is noise off-tick.
    task automatic do_ticks(input int n, input int half, input int kind);
        for (int i = 0; i < n; i++) begin
            sampleClk = 1'b1;
            bitIn     = gen_bit(kind, i);
            step();
            for (int h = 1; h < half; h++) begin
                bitIn = 1'($urandom_range(0, 1));
                step();
            end
            sampleClk = 1'b0;
            for (int h = 0; h < half; h++) begin
                bitIn = 1'($urandom_range(0, 1));
                step();
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_data", 32'(outData), 32'd0);
        chk("rst_valid", 32'(outValid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        sampleClk  = 1'b0;
        bitIn      = 1'b0;
        outReady   = 1'b1;
        ready_rand = 1'b0;
        valid_seen = 0;
        step();
        step();
        do_reset();

        // All ones at the slow sample rate: frame 1 silent, then one pulse per frame.
        valid_seen = 0;
        do_ticks(N, 50, 1);
        chk("ones_frame1_silent", 32'(valid_seen), 32'd0);
        do_ticks(2 * N, 50, 1);
        chk("ones_pulses", 32'(valid_seen), 32'd2);
        chk("ones_value", 32'(outData), 32'd4096);

        // Keep going well past integrator wrap.
        do_ticks(4 * N, 2, 1);
        chk("ones_wrapped", 32'(outData), 32'd4096);

        do_ticks(3 * N, 2, 0);
        chk("zeros_value", 32'(outData), 32'd0);
        chk("zeros_overrun", 32'(overrun), 32'd0);

        do_ticks(3 * N, 2, 2);
        chk("alt_value", 32'(outData), 32'd2048);

        do_ticks(3 * N, 3, 3);
        chk("p1110_value", 32'(outData), 32'd3072);

        // Downstream stalls for three frames.
        outReady = 1'b0;
        do_ticks(3 * N, 2, 4);
        chk("hold_valid", 32'(outValid), 32'd1);
        chk("hold_overrun", 32'(overrun), 32'd1);
        chk("hold_data", 32'(outData), 32'(pend_val));
        outReady = 1'b1;
        step();
        chk("drain_valid", 32'(outValid), 32'd0);
        chk("drain_overrun", 32'(overrun), 32'd1);

        // Reset at tick 37 of frame 3, then two full frames to the next word.
        do_reset();
        do_ticks(2 * N + 37, 2, 4);
        do_reset();
        valid_seen = 0;
        do_ticks(2 * N - 1, 2, 4);
        chk("post_rst_silent", 32'(valid_seen), 32'd0);
        do_ticks(1, 2, 4);
        chk("post_rst_first", 32'(valid_seen), 32'd1);

        ready_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            do_ticks(N, $urandom_range(1, 3), 4);
        end
        ready_rand = 1'b0;
        outReady   = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
